// File: rtl/sensor_cortinas_multi.sv
// N-channel motorised blind controller with time-based position tracking.
// Shared tick prescaler, per-channel dead time before every start/reversal.
module sensor_cortinas_multi #(
    parameter int N_CH       = 4,
    parameter int POS_W      = 8,
    parameter int TRAVEL_MAX = 200,
    parameter int TICK_DIV   = 1000,
    parameter int DEADTIME   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    startPer,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [3:0]              cmd_ch,
    input  logic [1:0]              cmd_op,
    input  logic [POS_W-1:0]        cmd_target,
    output logic [N_CH-1:0]         updown,
    output logic [N_CH-1:0]         backward,
    output logic [N_CH-1:0]         busy,
    output logic [N_CH-1:0]         done,
    output logic                    cmd_err,
    output logic [N_CH*POS_W-1:0]   position
);

    localparam int CW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DEADTIME + 1);
    localparam logic [CW-1:0]    CLAST = CW'(TICK_DIV - 1);
    localparam logic [DW-1:0]    DLAST = DW'(DEADTIME - 1);
    localparam logic [POS_W-1:0] TMAX  = POS_W'(TRAVEL_MAX);

    localparam logic [1:0] OP_STOP  = 2'b00;
    localparam logic [1:0] OP_LOWER = 2'b01;
    localparam logic [1:0] OP_GOTO  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEAD,
        S_UP,
        S_DOWN
    } state_e;

    state_e             state_q [N_CH];
    state_e             state_d [N_CH];
    logic [POS_W-1:0]   pos_q   [N_CH];
    logic [POS_W-1:0]   pos_d   [N_CH];
    logic [POS_W-1:0]   tgt_q   [N_CH];
    logic [POS_W-1:0]   tgt_d   [N_CH];
    logic [DW-1:0]      dead_q  [N_CH];
    logic [DW-1:0]      dead_d  [N_CH];
    logic [N_CH-1:0]    dir_q, dir_d;
    logic [N_CH-1:0]    done_q, done_d;
    logic [N_CH-1:0]    updown_q, updown_d;
    logic [N_CH-1:0]    backward_q, backward_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               cmd_err_q, cmd_err_d;

    logic               tick;
    logic               accept;
    logic               ch_ok;
    logic               hit;
    logic               want_down;
    logic               moving;
    logic [POS_W-1:0]   cmd_tgt;
    logic [POS_W-1:0]   nxt;

    assign cmd_ready = startPer & reset;
    assign accept    = cmd_valid & cmd_ready;
    assign ch_ok     = ({1'b0, cmd_ch} < 5'(N_CH));
    assign tick      = startPer && (cnt_q == CLAST);

    always_comb begin
        cnt_d = (!startPer || tick) ? '0 : cnt_q + 1'b1;
    end

    always_comb begin
        case (cmd_op)
            OP_LOWER: cmd_tgt = TMAX;
            OP_GOTO:  cmd_tgt = (cmd_target > TMAX) ? TMAX : cmd_target;
            default:  cmd_tgt = '0;
        endcase
    end

    always_comb begin
        cmd_err_d  = accept && !ch_ok;
        hit        = 1'b0;
        want_down  = 1'b0;
        moving     = 1'b0;
        nxt        = '0;
        dir_d      = dir_q;
        done_d     = '0;
        updown_d   = '0;
        backward_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            pos_d[i]   = pos_q[i];
            tgt_d[i]   = tgt_q[i];
            dead_d[i]  = dead_q[i];
            hit        = accept && ch_ok && (cmd_ch == 4'(i));
            want_down  = cmd_tgt > pos_q[i];
            moving     = (state_q[i] == S_UP) || (state_q[i] == S_DOWN);
            nxt        = pos_q[i];
            if (!startPer) begin
                state_d[i] = S_IDLE;
            end else if (hit) begin
                // A command on this channel pre-empts any tick step this edge
                if (cmd_op == OP_STOP) begin
                    state_d[i] = S_IDLE;
                end else if (cmd_tgt == pos_q[i]) begin
                    state_d[i] = S_IDLE;
                    done_d[i]  = 1'b1;
                end else begin
                    tgt_d[i] = cmd_tgt;
                    dir_d[i] = want_down;
                    if (!(moving && (dir_q[i] == want_down))) begin
                        state_d[i] = S_DEAD;
                        dead_d[i]  = '0;
                    end
                end
            end else begin
                case (state_q[i])
                    S_DEAD: begin
                        if (dead_q[i] == DLAST) begin
                            state_d[i] = dir_q[i] ? S_DOWN : S_UP;
                        end else begin
                            dead_d[i] = dead_q[i] + 1'b1;
                        end
                    end
                    S_UP: begin
                        if (tick) begin
                            nxt      = (pos_q[i] == '0) ? '0 : pos_q[i] - 1'b1;
                            pos_d[i] = nxt;
                            if (nxt == tgt_q[i]) begin
                                state_d[i] = S_IDLE;
                                done_d[i]  = 1'b1;
                            end
                        end
                    end
                    S_DOWN: begin
                        if (tick) begin
                            nxt      = (pos_q[i] >= TMAX) ? TMAX : pos_q[i] + 1'b1;
                            pos_d[i] = nxt;
                            if (nxt == tgt_q[i]) begin
                                state_d[i] = S_IDLE;
                                done_d[i]  = 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
            // Relays follow the registered state one edge later
            updown_d[i]   = startPer && (state_q[i] == S_UP);
            backward_d[i] = startPer && (state_q[i] == S_DOWN);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            cmd_err_q  <= 1'b0;
            dir_q      <= '0;
            done_q     <= '0;
            updown_q   <= '0;
            backward_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= S_IDLE;
                pos_q[i]   <= '0;
                tgt_q[i]   <= '0;
                dead_q[i]  <= '0;
            end
        end else begin
            cnt_q      <= cnt_d;
            cmd_err_q  <= cmd_err_d;
            dir_q      <= dir_d;
            done_q     <= done_d;
            updown_q   <= updown_d;
            backward_q <= backward_d;
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                pos_q[i]   <= pos_d[i];
                tgt_q[i]   <= tgt_d[i];
                dead_q[i]  <= dead_d[i];
            end
        end
    end

    assign updown   = updown_q;
    assign backward = backward_q;
    assign done     = done_q;
    assign cmd_err  = cmd_err_q;

    for (genvar g = 0; g < N_CH; g++) begin : g_out
        assign position[g*POS_W +: POS_W] = pos_q[g];
        assign busy[g] = (state_q[g] != S_IDLE);
    end

endmodule

// File: tb/tb_sensor_cortinas_multi.sv
// Scoreboard bench for sensor_cortinas_multi: directed scenarios plus
// a random command stream guarded by relay/position invariants.
module tb_sensor_cortinas_multi;

    localparam int N  = 2;
    localparam int PW = 8;
    localparam int TM = 10;
    localparam int TD = 4;
    localparam int DT = 3;

    localparam logic [1:0] STOP  = 2'b00;
    localparam logic [1:0] LOWER = 2'b01;
    localparam logic [1:0] RAISE = 2'b10;
    localparam logic [1:0] GOTO  = 2'b11;

    logic          clk = 1'b0;
    logic          reset;
    logic          startPer;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [3:0]    cmd_ch;
    logic [1:0]    cmd_op;
    logic [PW-1:0] cmd_target;
    logic [N-1:0]  updown;
    logic [N-1:0]  backward;
    logic [N-1:0]  busy;
    logic [N-1:0]  done;
    logic          cmd_err;
    logic [N*PW-1:0] position;

    int checks = 0;
    int errors = 0;
    int ph;
    bit sb_on = 1'b1;

    typedef struct {
        logic [1:0] done;
        logic       err;
        int         ch;
        logic [7:0] pos;
        bit         chkpos;
    } exp_t;

    exp_t q[$];

    sensor_cortinas_multi #(
        .N_CH(N), .POS_W(PW), .TRAVEL_MAX(TM),
        .TICK_DIV(TD), .DEADTIME(DT)
    ) dut (
        .clk(clk), .reset(reset), .startPer(startPer),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ch(cmd_ch), .cmd_op(cmd_op), .cmd_target(cmd_target),
        .updown(updown), .backward(backward), .busy(busy),
        .done(done), .cmd_err(cmd_err), .position(position)
    );

    always #5 clk = ~clk;

    // Reference prescaler phase: tick happens on the edge where ph==TD-1
    always @(posedge clk or negedge reset) begin
        if (!reset) ph <= 0;
        else if (!startPer) ph <= 0;
        else ph <= (ph == TD - 1) ? 0 : ph + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp_v);
        end
    endtask

    function automatic logic [7:0] pos_of(input int c);
        return position[c*PW +: PW];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int ch, input logic [1:0] op,
                         input logic [7:0] t);
        cmd_valid  = 1'b1;
        cmd_ch     = 4'(ch);
        cmd_op     = op;
        cmd_target = t;
        @(posedge clk);
        #1;
        cmd_valid  = 1'b0;
    endtask

    task automatic push(input logic [1:0] d, input logic e, input int ch,
                        input logic [7:0] p, input bit cp);
        exp_t x;
        x.done = d;
        x.err = e;
        x.ch = ch;
        x.pos = p;
        x.chkpos = cp;
        q.push_back(x);
    endtask

    task automatic align0();
        int n;
        n = 0;
        while (ph != 0 && n < 10) begin
            step();
            n++;
        end
    endtask

    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (reset) begin
                for (int c = 0; c < N; c++) begin
                    chk("inv_both_relays", 32'(updown[c] & backward[c]), 0);
                    chk("inv_pos_max", 32'(pos_of(c) <= TM), 1);
                end
                if (sb_on && (done != 0 || cmd_err)) begin
                    if (q.size() == 0) begin
                        chk("sb_unexpected", {done, cmd_err}, 0);
                    end else begin
                        x = q.pop_front();
                        chk("sb_done", 32'(done), 32'(x.done));
                        chk("sb_err", 32'(cmd_err), 32'(x.err));
                        if (x.chkpos)
                            chk("sb_pos", 32'(pos_of(x.ch)), 32'(x.pos));
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int h;
        int z;
        bit seen;
        reset = 1'b0;
        startPer = 1'b1;
        cmd_valid = 1'b0;
        cmd_ch = '0;
        cmd_op = '0;
        cmd_target = '0;
        #2;
        chk("rst_updown", 32'(updown), 0);
        chk("rst_backward", 32'(backward), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(cmd_err), 0);
        chk("rst_pos", 32'(position), 0);
        step();
        step();
        reset = 1'b1;
        step();

        // GOTO 5 on ch0 from a known prescaler phase
        align0();
        push(2'b01, 1'b0, 0, 8'd5, 1'b1);
        issue(0, GOTO, 8'd5);
        n = 0;
        seen = 1'b0;
        while (!backward[0] && n < 50) begin
            if (updown[0]) seen = 1'b1;
            step();
            n++;
        end
        chk("t1_relay_latency", n, DT + 1);
        h = 0;
        while (backward[0] && h < 100) begin
            if (updown[0]) seen = 1'b1;
            h++;
            step();
        end
        chk("t1_relay_high", h, 5 * TD);
        chk("t1_pos", 32'(pos_of(0)), 5);
        chk("t1_no_updown", 32'(seen), 0);

        // RAISE then reverse with LOWER while moving up
        issue(0, RAISE, 8'd0);
        n = 0;
        while (!updown[0] && n < 50) begin
            step();
            n++;
        end
        chk("t2_up_on", 32'(updown[0]), 1);
        push(2'b01, 1'b0, 0, 8'd10, 1'b1);
        issue(0, LOWER, 8'd0);
        n = 0;
        while (updown[0] && n < 10) begin
            step();
            n++;
        end
        z = 0;
        while (!updown[0] && !backward[0] && z < 50) begin
            z++;
            step();
        end
        chk("t2_dead_cycles", z, DT);
        chk("t2_back_on", 32'(backward[0]), 1);
        n = 0;
        while (busy[0] && n < 200) begin
            step();
            n++;
        end
        chk("t2_pos_end", 32'(pos_of(0)), TM);

        // Clamped GOTO on ch1, then a GOTO to where it already is
        push(2'b10, 1'b0, 1, 8'd10, 1'b1);
        issue(1, GOTO, 8'd200);
        n = 0;
        while (busy[1] && n < 200) begin
            step();
            n++;
        end
        chk("t3_clamp_pos", 32'(pos_of(1)), TM);
        push(2'b10, 1'b0, 1, 8'd10, 1'b1);
        issue(1, GOTO, 8'd10);
        chk("t3_done_next", 32'(done), 2'b10);
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (updown != 0 || backward != 0 || busy != 0) seen = 1'b1;
        end
        chk("t3_no_motion", 32'(seen), 0);

        // Two channels moving; STOP one; bad channel index
        issue(0, RAISE, 8'd0);
        issue(1, RAISE, 8'd0);
        n = 0;
        while (updown != 2'b11 && n < 50) begin
            step();
            n++;
        end
        chk("t4_both_up", 32'(updown), 2'b11);
        push(2'b01, 1'b0, 0, 8'd0, 1'b1);
        issue(1, STOP, 8'd0);
        chk("t4_busy_after_stop", 32'(busy), 2'b01);
        step();
        chk("t4_relays_after_stop", 32'(updown), 2'b01);
        push(2'b00, 1'b1, 0, 8'd0, 1'b0);
        q.push_front(q.pop_back());
        issue(3, GOTO, 8'd5);
        chk("t4_err_pulse", 32'(cmd_err), 1);
        step();
        chk("t4_err_one_cycle", 32'(cmd_err), 0);
        chk("t4_err_no_change", {updown, busy}, 4'b0101);
        n = 0;
        while (busy[0] && n < 200) begin
            step();
            n++;
        end
        chk("t4_ch0_home", 32'(pos_of(0)), 0);

        // Disable while lowering at position 7, then resume
        align0();
        issue(0, LOWER, 8'd0);
        n = 0;
        while (pos_of(0) != 8'd7 && n < 200) begin
            step();
            n++;
        end
        startPer = 1'b0;
        step();
        chk("t5_relay_off", 32'(backward[0]), 0);
        chk("t5_idle", 32'(busy), 0);
        chk("t5_not_ready", 32'(cmd_ready), 0);
        cmd_valid = 1'b1;
        cmd_ch = 4'd0;
        cmd_op = LOWER;
        step();
        step();
        step();
        cmd_valid = 1'b0;
        chk("t5_cmd_ignored", {busy, backward}, 0);
        chk("t5_pos_held", 32'(pos_of(0)), 7);
        startPer = 1'b1;
        step();
        align0();
        push(2'b01, 1'b0, 0, 8'd10, 1'b1);
        issue(0, LOWER, 8'd0);
        n = 0;
        while (!backward[0] && n < 50) begin
            step();
            n++;
        end
        chk("t5_resume_latency", n, DT + 1);
        chk("t5_resume_pos", 32'(pos_of(0)), 7);

        // Command landing on a tick edge suppresses that step
        step();
        step();
        chk("t6_phase", ph, TD - 1);
        issue(0, LOWER, 8'd0);
        chk("t6_no_step", 32'(pos_of(0)), 7);
        for (int k = 0; k < TD; k++) step();
        chk("t6_next_step", 32'(pos_of(0)), 8);
        n = 0;
        while (busy[0] && n < 200) begin
            step();
            n++;
        end
        chk("t6_pos_end", 32'(pos_of(0)), TM);

        // Asynchronous reset in the middle of motion
        issue(0, RAISE, 8'd0);
        n = 0;
        while (!updown[0] && n < 50) begin
            step();
            n++;
        end
        #2;
        reset = 1'b0;
        #1;
        chk("rst_mid_relays", {updown, backward}, 0);
        chk("rst_mid_pos", 32'(position), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step();
        chk("sb_drained", q.size(), 0);

        sb_on = 1'b0;
        for (int k = 0; k < 400; k++) begin
            cmd_valid  = ($urandom_range(0, 3) == 0);
            cmd_ch     = 4'($urandom_range(0, 2));
            cmd_op     = 2'($urandom_range(0, 3));
            cmd_target = 8'($urandom_range(0, 15));
            step();
        end
        cmd_valid = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
